// File: rtl/bram_stream_reader.sv
// bram_stream_reader
// Walks a contiguous range of a 1-cycle-latency block RAM and presents the
// words as a valid/ready stream with a last flag. A two-entry skid buffer
// absorbs the RAM latency so the consumer may stall on any cycle.
module bram_stream_reader #(
    parameter int MEMWIDTH  = 10,
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MEMWIDTH-1:0]  base_addr,
    input  logic [MEMWIDTH:0]    length,
    output logic                 busy,
    output logic                 done,
    output logic [MEMWIDTH-1:0]  raddr,
    input  logic [DATAWIDTH-1:0] rdata,
    output logic [DATAWIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [MEMWIDTH:0]   CNT_ONE = {{MEMWIDTH{1'b0}}, 1'b1};
    localparam logic [MEMWIDTH-1:0] PTR_ONE = {{(MEMWIDTH-1){1'b0}}, 1'b1};

    state_t                state_reg;
    state_t                state_next;

    // Burst bookkeeping; counters are one bit wider than the address so that
    // a full-memory burst (length = 2**MEMWIDTH) is representable.
    logic [MEMWIDTH-1:0]   ptr_reg;
    logic [MEMWIDTH:0]     len_reg;
    logic [MEMWIDTH:0]     issued_reg;
    logic [MEMWIDTH:0]     accepted_reg;

    // Set on the cycle whose RAM output carries a word we asked for.
    logic                  inflight_reg;

    // Two-entry output buffer, circular with head/tail pointers.
    logic [DATAWIDTH-1:0]  buf_mem [0:1];
    logic                  buf_head_reg;
    logic                  buf_tail_reg;
    logic [1:0]            buf_count_reg;

    logic                  start_accept;
    logic                  issue;
    logic                  pop;
    logic                  buf_wr;
    logic                  last_word;
    logic [2:0]            occupancy;

    assign start_accept = (state_reg == IDLE) && start;
    assign m_valid      = (buf_count_reg != 2'd0);
    assign m_data       = buf_mem[buf_head_reg];
    assign pop          = m_valid && m_ready;
    assign buf_wr       = inflight_reg;
    assign last_word    = ((accepted_reg + CNT_ONE) == len_reg);
    assign m_last       = m_valid && last_word;
    assign raddr        = ptr_reg;
    assign busy         = (state_reg == READ) || (state_reg == FINISH);
    assign done         = (state_reg == FINISH);

    // Words already buffered plus the one arriving from the RAM this cycle.
    assign occupancy    = {1'b0, buf_count_reg} + {2'b00, inflight_reg};

    // Issue a read only when the buffer is guaranteed a free slot when the
    // word lands: at most one slot committed, or a slot is freed right now.
    assign issue = (state_reg == READ) && (issued_reg < len_reg) &&
                   ((occupancy <= 3'd1) || pop);

    // Next-state logic for the burst sequencer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        state_next = FINISH;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                if (pop && m_last) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Burst parameters and the read pointer, which wraps modulo the depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
            len_reg <= '0;
        end else if (start_accept) begin
            ptr_reg <= base_addr;
            len_reg <= length;
        end else if (issue) begin
            ptr_reg <= ptr_reg + PTR_ONE;
        end
    end

    // Issued / accepted word counters, cleared at the start of each burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_reg   <= '0;
            accepted_reg <= '0;
        end else if (start_accept) begin
            issued_reg   <= '0;
            accepted_reg <= '0;
        end else begin
            if (issue) begin
                issued_reg <= issued_reg + CNT_ONE;
            end
            if (pop) begin
                accepted_reg <= accepted_reg + CNT_ONE;
            end
        end
    end

    // Remember that the RAM output next cycle belongs to this burst;
    // reset drops it, so a word in flight during reset is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= issue;
        end
    end

    // Buffer storage: the returning RAM word goes into the tail slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                buf_mem[i] <= '0;
            end
        end else if (buf_wr) begin
            buf_mem[buf_tail_reg] <= rdata;
        end
    end

    // Buffer pointers and fill count.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_head_reg  <= 1'b0;
            buf_tail_reg  <= 1'b0;
            buf_count_reg <= 2'd0;
        end else begin
            if (buf_wr) begin
                buf_tail_reg <= ~buf_tail_reg;
            end
            if (pop) begin
                buf_head_reg <= ~buf_head_reg;
            end
            case ({buf_wr, pop})
                2'b10:   buf_count_reg <= buf_count_reg + 2'd1;
                2'b01:   buf_count_reg <= buf_count_reg - 2'd1;
                default: buf_count_reg <= buf_count_reg;
            endcase
        end
    end

    // A write into a full buffer would lose data; the issue rule forbids it.
    buf_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(buf_wr && (buf_count_reg == 2'd2)));

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader
// Directed bursts against a preloaded RAM model; a scoreboard queue of the
// words each burst must deliver is compared against every stream handshake.
module tb_bram_stream_reader;

    localparam int MW = 10;
    localparam int DW = 32;
    localparam int DEPTH = 1 << MW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [MW-1:0] base_addr;
    logic [MW:0]   length;
    logic          busy;
    logic          done;
    logic [MW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    bram_stream_reader #(.MEMWIDTH(MW), .DATAWIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .raddr     (raddr),
        .rdata     (rdata),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    // RAM with a registered read, preloaded mem[i] = i.
    logic [DW-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    end
    always @(posedge clk) rdata <= mem[raddr];

    // Consumer ready: always-on or random ~50% duty.
    logic rand_ready = 1'b0;
    initial m_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: the words a burst must deliver, in order.
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;
    exp_t exp_q[$];

    task automatic model_burst(input int b, input int l);
        exp_t e;
        for (int k = 0; k < l; k++) begin
            e.data = mem[(b + k) % DEPTH];
            e.last = (k == l - 1);
            exp_q.push_back(e);
        end
    endtask

    int            hs_count   = 0;
    int            done_seen  = 0;
    logic [DW-1:0] last_word  = '0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    // Compare process: every cycle out of reset, check the stream against
    // the scoreboard and the hold-during-stall rule.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1'b1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            if (m_valid && exp_q.size() == 0) begin
                chk("unexpected_valid", m_valid, 1'b0);
            end
            if (m_valid && m_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("stream_data", m_data, e.data);
                chk("stream_last", m_last, e.last);
                hs_count++;
                if (m_last) last_word = m_data;
            end
            if (done) done_seen++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // Present a start command; returns just after the sampling edge (edge 0).
    task automatic start_burst(input int b, input int l, input bit expect_run);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = MW'(b);
        length    = (MW+1)'(l);
        if (expect_run) model_burst(b, l);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait for done with a cycle budget, then confirm busy has dropped.
    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk({name, "_done"}, done, 1'b1);
        @(negedge clk);
        chk({name, "_busy_after"}, busy, 1'b0);
    endtask

    int d0;
    int h0;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_raddr", raddr, 10'h000);
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_last", m_last, 1'b0);
        chk("rst_data", m_data, 32'h0);

        // Burst base 0x010, length 4, ready held high: cycle-exact timing.
        d0 = done_seen;
        start_burst(32'h010, 4, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c <= 4) chk($sformatf("t1_raddr_c%0d", c), raddr, MW'(16 + c - 1));
            chk($sformatf("t1_valid_c%0d", c), m_valid, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) chk($sformatf("t1_data_c%0d", c), m_data, DW'(16 + c - 3));
            chk($sformatf("t1_last_c%0d", c), m_last, (c == 6));
            chk($sformatf("t1_done_c%0d", c), done, (c == 7));
            chk($sformatf("t1_busy_c%0d", c), busy, (c <= 7));
        end
        chk("t1_last_word", last_word, 32'h13);
        chk("t1_done_count", done_seen - d0, 1);

        // Random back-pressure, 16 words from 0.
        rand_ready = 1'b1;
        d0 = done_seen;
        h0 = hs_count;
        start_burst(0, 16, 1'b1);
        wait_done("t2", 400);
        rand_ready = 1'b0;
        chk("t2_handshakes", hs_count - h0, 16);
        chk("t2_queue_empty", exp_q.size(), 0);
        chk("t2_done_count", done_seen - d0, 1);

        // Wrap from the top of memory.
        start_burst(32'h3FE, 4, 1'b1);
        wait_done("t3", 50);
        chk("t3_last_word", last_word, 32'h001);
        chk("t3_queue_empty", exp_q.size(), 0);

        // Zero-length burst: a single FINISH cycle.
        d0 = done_seen;
        start_burst(32'h055, 0, 1'b1);
        @(negedge clk);
        chk("t4_busy", busy, 1'b1);
        chk("t4_done", done, 1'b1);
        chk("t4_valid", m_valid, 1'b0);
        @(negedge clk);
        chk("t4_busy_idle", busy, 1'b0);
        chk("t4_done_idle", done, 1'b0);
        chk("t4_done_count", done_seen - d0, 1);

        // Start again mid-burst: must be ignored.
        d0 = done_seen;
        start_burst(32'h100, 6, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 10'h200;
        length    = 11'd3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t5", 50);
        repeat (5) @(negedge clk);
        chk("t5_queue_empty", exp_q.size(), 0);
        chk("t5_last_word", last_word, 32'h105);
        chk("t5_done_count", done_seen - d0, 1);

        // Reset after two of eight words accepted.
        h0 = hs_count;
        start_burst(0, 8, 1'b1);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        d0 = done_seen;
        chk("t6_accepted_before_rst", hs_count - h0, 2);
        @(negedge clk);
        chk("t6_busy", busy, 1'b0);
        chk("t6_done", done, 1'b0);
        chk("t6_raddr", raddr, 10'h000);
        chk("t6_valid", m_valid, 1'b0);
        chk("t6_last", m_last, 1'b0);
        chk("t6_data", m_data, 32'h0);
        repeat (10) @(negedge clk);
        chk("t6_no_done", done_seen - d0, 0);
        start_burst(32'h020, 8, 1'b1);
        wait_done("t6b", 50);
        chk("t6b_queue_empty", exp_q.size(), 0);
        chk("t6b_last_word", last_word, 32'h027);

        // Full-memory burst.
        h0 = hs_count;
        start_burst(0, 1024, 1'b1);
        wait_done("t7", 1200);
        chk("t7_handshakes", hs_count - h0, 1024);
        chk("t7_last_word", last_word, 32'h3FF);
        chk("t7_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
